// File: rtl/axi_slave_port.sv
// axi_slave_port: crossbar output port toward one downstream AXI slave.
// Replays packed AR/AW/W requests as AXI transactions and forwards R/B responses
// back in packed form. One read and one write burst are in flight at a time; the
// read and write paths are fully independent. PROTO_ERR_o is sticky until reset.
module axi_slave_port #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        AXI_CLK_i,
    input  logic        AXI_RST_i,
    // packed request / response side
    input  logic        S_AR_VALID_i,
    output logic        S_AR_READY_o,
    input  logic [48:0] S_AR_DATA_i,
    input  logic        S_AW_VALID_i,
    output logic        S_AW_READY_o,
    input  logic [48:0] S_AW_DATA_i,
    input  logic        S_W_VALID_i,
    output logic        S_W_READY_o,
    input  logic [36:0] S_W_DATA_i,
    output logic        S_R_VALID_o,
    input  logic        S_R_READY_i,
    output logic [42:0] S_R_DATA_o,
    output logic        S_B_VALID_o,
    input  logic        S_B_READY_i,
    output logic [9:0]  S_B_DATA_o,
    // AXI read address / data
    output logic [7:0]  ARID_o,
    output logic [31:0] ARADDR_o,
    output logic [3:0]  ARLEN_o,
    output logic [2:0]  ARSIZE_o,
    output logic [1:0]  ARBURST_o,
    output logic        ARVALID_o,
    input  logic        ARREADY_i,
    input  logic [7:0]  RID_i,
    input  logic [31:0] RDATA_i,
    input  logic [1:0]  RRESP_i,
    input  logic        RLAST_i,
    input  logic        RVALID_i,
    output logic        RREADY_o,
    // AXI write address / data / response
    output logic [7:0]  AWID_o,
    output logic [31:0] AWADDR_o,
    output logic [3:0]  AWLEN_o,
    output logic [2:0]  AWSIZE_o,
    output logic [1:0]  AWBURST_o,
    output logic        AWVALID_o,
    input  logic        AWREADY_i,
    output logic [31:0] WDATA_o,
    output logic [3:0]  WSTRB_o,
    output logic        WLAST_o,
    output logic        WVALID_o,
    input  logic        WREADY_i,
    input  logic [7:0]  BID_i,
    input  logic [1:0]  BRESP_i,
    input  logic        BVALID_i,
    output logic        BREADY_o,
    output logic        PROTO_ERR_o
);

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } req_t;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;
    req_t     ar_q, aw_q;
    logic [3:0] rcnt, wcnt;
    logic       r_hs, w_hs, r_err, w_err, b_err, w_last;

    // Request as it is replayed downstream: address made relative to this slave.
    function automatic req_t rebase(input req_t r);
        req_t o = r;
        o.addr = r.addr - BASE_ADDR;
        return o;
    endfunction

    assign ARID_o    = ar_q.id;
    assign ARADDR_o  = ar_q.addr;
    assign ARLEN_o   = ar_q.len;
    assign ARSIZE_o  = ar_q.size;
    assign ARBURST_o = ar_q.burst;
    assign AWID_o    = aw_q.id;
    assign AWADDR_o  = aw_q.addr;
    assign AWLEN_o   = aw_q.len;
    assign AWSIZE_o  = aw_q.size;
    assign AWBURST_o = aw_q.burst;

    // Data paths are pure wires; only the valid/ready qualifiers depend on state.
    assign S_R_DATA_o = {RID_i, RDATA_i, RRESP_i, RLAST_i};
    assign S_B_DATA_o = {BID_i, BRESP_i};
    assign WDATA_o    = S_W_DATA_i[36:5];
    assign WSTRB_o    = S_W_DATA_i[4:1];
    assign w_last     = (wcnt == aw_q.len);

    // Read path: next-state and handshake qualifiers.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        r_next       = r_state;
        S_AR_READY_o = 1'b0;
        ARVALID_o    = 1'b0;
        S_R_VALID_o  = 1'b0;
        RREADY_o     = 1'b0;
        r_hs         = 1'b0;
        r_err        = 1'b0;
        case (r_state)
            R_IDLE: begin
                S_AR_READY_o = 1'b1;
                if (S_AR_VALID_i) r_next = R_ADDR;
            end
            R_ADDR: begin
                ARVALID_o = 1'b1;
                if (ARREADY_i) r_next = R_DATA;
            end
            R_DATA: begin
                S_R_VALID_o = RVALID_i;
                RREADY_o    = S_R_READY_i;
                r_hs        = RVALID_i & S_R_READY_i;
                if (r_hs) begin
                    // Early RLAST and missing RLAST at beat len are the same mismatch.
                    r_err = (RID_i != ar_q.id) | (RLAST_i != (rcnt == ar_q.len));
                    if (RLAST_i) r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read path: state, captured AR fields and beat counter.
    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            r_state <= R_IDLE;
            ar_q    <= '0;
            rcnt    <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
            r_state <= r_next;
            if (r_state == R_IDLE && S_AR_VALID_i) begin
                ar_q <= rebase(req_t'(S_AR_DATA_i));
                rcnt <= '0;
            end else if (r_hs) begin
                rcnt <= rcnt + 4'd1;
            end
        end
    end

    // Write path: next-state and handshake qualifiers.
    always_comb begin
        w_next       = w_state;
        S_AW_READY_o = 1'b0;
        AWVALID_o    = 1'b0;
        WVALID_o     = 1'b0;
        S_W_READY_o  = 1'b0;
        WLAST_o      = 1'b0;
        S_B_VALID_o  = 1'b0;
        BREADY_o     = 1'b0;
        w_hs         = 1'b0;
        w_err        = 1'b0;
        b_err        = 1'b0;
        case (w_state)
            W_IDLE: begin
                S_AW_READY_o = 1'b1;
                if (S_AW_VALID_i) w_next = W_ADDR;
            end
            W_ADDR: begin
                AWVALID_o = 1'b1;
                if (AWREADY_i) w_next = W_DATA;
            end
            W_DATA: begin
                WVALID_o    = S_W_VALID_i;
                S_W_READY_o = WREADY_i;
                WLAST_o     = w_last;
                w_hs        = S_W_VALID_i & WREADY_i;
                if (w_hs) begin
                    // The local count owns WLAST; a disagreeing upstream last bit is only flagged.
                    w_err = (S_W_DATA_i[0] != w_last);
                    if (w_last) w_next = W_RESP;
                end
            end
            W_RESP: begin
                S_B_VALID_o = BVALID_i;
                BREADY_o    = S_B_READY_i;
                if (BVALID_i && S_B_READY_i) begin
                    b_err  = (BID_i != aw_q.id);
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write path: state, captured AW fields and beat counter.
    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            w_state <= W_IDLE;
            aw_q    <= '0;
            wcnt    <= '0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && S_AW_VALID_i) begin
                aw_q <= rebase(req_t'(S_AW_DATA_i));
                wcnt <= '0;
            end else if (w_hs) begin
                wcnt <= wcnt + 4'd1;
            end
        end
    end

    // Sticky protocol-violation flag from either path.
    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i)                  PROTO_ERR_o <= 1'b0;
        else if (r_err | w_err | b_err)  PROTO_ERR_o <= 1'b1;
    end

endmodule

// File: tb/tb_axi_slave_port.sv
// Testbench for axi_slave_port: table of address-rebasing vectors, directed
// multi-cycle corner cases, and randomized bursts with backpressure checked
// against a transaction-level model (expected address, beat count, WLAST
// position, pass-through data and the sticky protocol-error flag).
module tb_axi_slave_port;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        AXI_CLK_i = 1'b0;
    logic        AXI_RST_i;
    logic        S_AR_VALID_i, S_AR_READY_o;
    logic [48:0] S_AR_DATA_i;
    logic        S_AW_VALID_i, S_AW_READY_o;
    logic [48:0] S_AW_DATA_i;
    logic        S_W_VALID_i, S_W_READY_o;
    logic [36:0] S_W_DATA_i;
    logic        S_R_VALID_o, S_R_READY_i;
    logic [42:0] S_R_DATA_o;
    logic        S_B_VALID_o, S_B_READY_i;
    logic [9:0]  S_B_DATA_o;
    logic [7:0]  ARID_o, AWID_o, RID_i, BID_i;
    logic [31:0] ARADDR_o, AWADDR_o, RDATA_i, WDATA_o;
    logic [3:0]  ARLEN_o, AWLEN_o, WSTRB_o;
    logic [2:0]  ARSIZE_o, AWSIZE_o;
    logic [1:0]  ARBURST_o, AWBURST_o, RRESP_i, BRESP_i;
    logic        ARVALID_o, ARREADY_i, RLAST_i, RVALID_i, RREADY_o;
    logic        AWVALID_o, AWREADY_i, WLAST_o, WVALID_o, WREADY_i;
    logic        BVALID_i, BREADY_o, PROTO_ERR_o;

    axi_slave_port #(.BASE_ADDR(BASE)) dut (
        .AXI_CLK_i(AXI_CLK_i), .AXI_RST_i(AXI_RST_i),
        .S_AR_VALID_i(S_AR_VALID_i), .S_AR_READY_o(S_AR_READY_o), .S_AR_DATA_i(S_AR_DATA_i),
        .S_AW_VALID_i(S_AW_VALID_i), .S_AW_READY_o(S_AW_READY_o), .S_AW_DATA_i(S_AW_DATA_i),
        .S_W_VALID_i(S_W_VALID_i), .S_W_READY_o(S_W_READY_o), .S_W_DATA_i(S_W_DATA_i),
        .S_R_VALID_o(S_R_VALID_o), .S_R_READY_i(S_R_READY_i), .S_R_DATA_o(S_R_DATA_o),
        .S_B_VALID_o(S_B_VALID_o), .S_B_READY_i(S_B_READY_i), .S_B_DATA_o(S_B_DATA_o),
        .ARID_o(ARID_o), .ARADDR_o(ARADDR_o), .ARLEN_o(ARLEN_o), .ARSIZE_o(ARSIZE_o),
        .ARBURST_o(ARBURST_o), .ARVALID_o(ARVALID_o), .ARREADY_i(ARREADY_i),
        .RID_i(RID_i), .RDATA_i(RDATA_i), .RRESP_i(RRESP_i), .RLAST_i(RLAST_i),
        .RVALID_i(RVALID_i), .RREADY_o(RREADY_o),
        .AWID_o(AWID_o), .AWADDR_o(AWADDR_o), .AWLEN_o(AWLEN_o), .AWSIZE_o(AWSIZE_o),
        .AWBURST_o(AWBURST_o), .AWVALID_o(AWVALID_o), .AWREADY_i(AWREADY_i),
        .WDATA_o(WDATA_o), .WSTRB_o(WSTRB_o), .WLAST_o(WLAST_o), .WVALID_o(WVALID_o),
        .WREADY_i(WREADY_i), .BID_i(BID_i), .BRESP_i(BRESP_i), .BVALID_i(BVALID_i),
        .BREADY_o(BREADY_o), .PROTO_ERR_o(PROTO_ERR_o)
    );

    always #5 AXI_CLK_i = ~AXI_CLK_i;

    int checks = 0;
    int failures = 0;
    bit exp_err = 1'b0;   // model of the sticky error flag

    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven at the falling edge, outputs sampled 1ns later.
    task automatic step();
        @(posedge AXI_CLK_i);
        @(negedge AXI_CLK_i);
    endtask

    task automatic idle_inputs();
        S_AR_VALID_i = 0; S_AR_DATA_i = '0; S_AW_VALID_i = 0; S_AW_DATA_i = '0;
        S_W_VALID_i = 0; S_W_DATA_i = '0; S_R_READY_i = 0; S_B_READY_i = 0;
        ARREADY_i = 0; AWREADY_i = 0; WREADY_i = 0;
        RID_i = '0; RDATA_i = '0; RRESP_i = '0; RLAST_i = 0; RVALID_i = 0;
        BID_i = '0; BRESP_i = '0; BVALID_i = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        AXI_RST_i = 0;
        step(); step();
        AXI_RST_i = 1;
        exp_err = 1'b0;
        #1 check("err_after_reset", PROTO_ERR_o, 0);
    endtask

    function automatic bit coin(input bit bp);
        return bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    // One read burst. last_at is the beat index the slave flags with RLAST.
    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [31:0] exp_addr,
                           input int last_at, input logic [7:0] rid, input int ar_wait, input bit bp);
        int beats, cyc;
        bit rv, rr, rl;
        logic [31:0] rd;
        logic [1:0]  rs;
        S_AR_VALID_i = 1; S_AR_DATA_i = {id, addr, len, size, burst};
        #1 check("ar_ready_idle", S_AR_READY_o, 1);
        step();
        S_AR_VALID_i = 0; S_AR_DATA_i = {17'($urandom), $urandom};
        #1;
        check("arvalid", ARVALID_o, 1);
        check("araddr", ARADDR_o, exp_addr);
        check("arid", ARID_o, id);
        check("arlen", ARLEN_o, len);
        check("arsize", ARSIZE_o, size);
        check("arburst", ARBURST_o, burst);
        for (int i = 1; i < ar_wait; i++) begin
            step();
            #1;
            check("arvalid_hold", ARVALID_o, 1);
            check("araddr_hold", ARADDR_o, exp_addr);
            check("ar_ready_busy", S_AR_READY_o, 0);
        end
        ARREADY_i = 1;
        step();
        ARREADY_i = 0;
        beats = 0; cyc = 0;
        while (beats <= last_at && cyc < 300) begin
            rv = coin(bp); rr = coin(bp); rl = (beats == last_at);
            rd = $urandom; rs = 2'($urandom_range(0, 3));
            RVALID_i = rv; S_R_READY_i = rr; RID_i = rid; RDATA_i = rd; RRESP_i = rs; RLAST_i = rl;
            #1;
            check("r_valid", S_R_VALID_o, rv);
            check("r_ready", RREADY_o, rr);
            check("r_data", S_R_DATA_o, {rid, rd, rs, rl});
            check("ar_ready_busy", S_AR_READY_o, 0);
            if (rv && rr) beats++;
            step();
            cyc++;
        end
        RVALID_i = 0; S_R_READY_i = 0; RLAST_i = 0;
        check("r_beats", beats, last_at + 1);
        if (rid != id || last_at != int'(len)) exp_err = 1'b1;
        #1;
        check("r_back_idle", S_AR_READY_o, 1);
        check("r_err", PROTO_ERR_o, exp_err);
    endtask

    // One write burst. bad_last_at (-1 = none) is the beat whose upstream last bit is inverted.
    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [31:0] exp_addr,
                            input int bad_last_at, input logic [7:0] bid, input int aw_wait, input bit bp);
        int beats, cyc;
        bit wv, wr, bv, br, done, il;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [1:0]  bresp;
        S_AW_VALID_i = 1; S_AW_DATA_i = {id, addr, len, size, burst};
        #1 check("aw_ready_idle", S_AW_READY_o, 1);
        step();
        S_AW_VALID_i = 0; S_AW_DATA_i = {17'($urandom), $urandom};
        S_W_VALID_i = 1; WREADY_i = 1;
        #1;
        check("awvalid", AWVALID_o, 1);
        check("awaddr", AWADDR_o, exp_addr);
        check("awid", AWID_o, id);
        check("awlen", AWLEN_o, len);
        check("awsize", AWSIZE_o, size);
        check("awburst", AWBURST_o, burst);
        check("w_ready_in_addr", S_W_READY_o, 0);
        check("w_valid_in_addr", WVALID_o, 0);
        S_W_VALID_i = 0; WREADY_i = 0;
        for (int i = 1; i < aw_wait; i++) begin
            step();
            #1;
            check("awvalid_hold", AWVALID_o, 1);
            check("awaddr_hold", AWADDR_o, exp_addr);
        end
        AWREADY_i = 1;
        step();
        AWREADY_i = 0;
        beats = 0; cyc = 0;
        while (beats <= int'(len) && cyc < 300) begin
            wv = coin(bp); wr = coin(bp);
            wd = $urandom; ws = 4'($urandom_range(0, 15));
            il = (beats == int'(len)) ^ (beats == bad_last_at);
            S_W_VALID_i = wv; WREADY_i = wr; S_W_DATA_i = {wd, ws, il};
            #1;
            check("w_valid", WVALID_o, wv);
            check("w_ready", S_W_READY_o, wr);
            check("wdata", WDATA_o, wd);
            check("wstrb", WSTRB_o, ws);
            check("wlast", WLAST_o, beats == int'(len));
            check("aw_ready_busy", S_AW_READY_o, 0);
            if (wv && wr) beats++;
            step();
            cyc++;
        end
        S_W_VALID_i = 0; WREADY_i = 0;
        check("w_beats", beats, int'(len) + 1);
        done = 0; cyc = 0;
        bresp = bp ? 2'($urandom_range(0, 3)) : 2'b00;
        while (!done && cyc < 100) begin
            bv = coin(bp); br = coin(bp);
            BVALID_i = bv; S_B_READY_i = br; BID_i = bid; BRESP_i = bresp;
            #1;
            check("b_valid", S_B_VALID_o, bv);
            check("b_ready", BREADY_o, br);
            check("b_data", S_B_DATA_o, {bid, bresp});
            if (bv && br) done = 1;
            step();
            cyc++;
        end
        BVALID_i = 0; S_B_READY_i = 0;
        check("b_handshake", done, 1);
        if (bid != id || (bad_last_at >= 0 && bad_last_at <= int'(len))) exp_err = 1'b1;
        #1;
        check("w_back_idle", S_AW_READY_o, 1);
        check("w_err", PROTO_ERR_o, exp_err);
    endtask

    // Random bursts; inject enables occasional protocol violations.
    task automatic random_phase(input int n, input bit inject);
        logic [7:0]  id, rid;
        logic [31:0] addr;
        logic [3:0]  len;
        int          other;
        for (int t = 0; t < n; t++) begin
            id = 8'($urandom); addr = $urandom; len = 4'($urandom_range(0, 15));
            rid = (inject && $urandom_range(0, 7) == 0) ? 8'($urandom) : id;
            if ($urandom_range(0, 1) == 0) begin
                other = (inject && $urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : int'(len);
                do_read(id, addr, len, 3'($urandom), 2'($urandom), addr - BASE, other, rid,
                        $urandom_range(1, 3), 1);
            end else begin
                other = (inject && $urandom_range(0, 7) == 0) ? $urandom_range(0, int'(len)) : -1;
                do_write(id, addr, len, 3'($urandom), 2'($urandom), addr - BASE, other, rid,
                         $urandom_range(1, 3), 1);
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'h21, 32'h1000_0040, 4'd3,  3'd2, 2'd1, 32'h0000_0040};
        vecs[1] = '{8'h05, 32'h1000_0000, 4'd0,  3'd2, 2'd1, 32'h0000_0000};
        vecs[2] = '{8'hFF, 32'h0FFF_FFFC, 4'd15, 3'd0, 2'd0, 32'hFFFF_FFFC};
        vecs[3] = '{8'h80, 32'hFFFF_FFFF, 4'd7,  3'd1, 2'd2, 32'hEFFF_FFFF};
        vecs[4] = '{8'h00, 32'h2345_6788, 4'd1,  3'd2, 2'd1, 32'h1345_6788};

        // Reset values, with every qualifying input asserted to prove gating.
        idle_inputs();
        AXI_RST_i = 0;
        RVALID_i = 1; S_R_READY_i = 1; S_W_VALID_i = 1; WREADY_i = 1; BVALID_i = 1; S_B_READY_i = 1;
        step();
        #1;
        check("rst_ar_ready", S_AR_READY_o, 1);
        check("rst_aw_ready", S_AW_READY_o, 1);
        check("rst_arvalid", ARVALID_o, 0);
        check("rst_awvalid", AWVALID_o, 0);
        check("rst_wvalid", WVALID_o, 0);
        check("rst_rready", RREADY_o, 0);
        check("rst_bready", BREADY_o, 0);
        check("rst_r_valid", S_R_VALID_o, 0);
        check("rst_b_valid", S_B_VALID_o, 0);
        check("rst_err", PROTO_ERR_o, 0);
        check("rst_araddr", ARADDR_o, 0);
        check("rst_awid", AWID_o, 0);
        apply_reset();

        // Address rebasing and clean bursts from the vector table.
        for (int i = 0; i < 5; i++) begin
            do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                    vecs[i].exp_addr, int'(vecs[i].len), vecs[i].id, 1, 0);
            do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                     vecs[i].exp_addr, -1, vecs[i].id, 1, 0);
        end

        // ARREADY held low five cycles.
        do_read(8'h44, BASE + 32'h100, 4'd2, 3'd2, 2'd1, 32'h100, 2, 8'h44, 5, 0);
        // Two-beat write, B = {32, OKAY}.
        do_write(8'h32, BASE + 32'h80, 4'd1, 3'd2, 2'd1, 32'h80, -1, 8'h32, 1, 0);
        check("b_data_plan", {BID_i, BRESP_i} == 10'h0C8, 1);

        // Read and write handshaking in the same cycles.
        S_AR_VALID_i = 1; S_AR_DATA_i = {8'h61, BASE + 32'h10, 4'd0, 3'd2, 2'd1};
        S_AW_VALID_i = 1; S_AW_DATA_i = {8'h62, BASE + 32'h20, 4'd0, 3'd2, 2'd1};
        #1;
        check("both_ar_ready", S_AR_READY_o, 1);
        check("both_aw_ready", S_AW_READY_o, 1);
        step();
        S_AR_VALID_i = 0; S_AW_VALID_i = 0;
        #1;
        check("both_arvalid", ARVALID_o, 1);
        check("both_awvalid", AWVALID_o, 1);
        check("both_araddr", ARADDR_o, 32'h10);
        check("both_awaddr", AWADDR_o, 32'h20);
        ARREADY_i = 1; AWREADY_i = 1;
        step();
        ARREADY_i = 0; AWREADY_i = 0;
        RVALID_i = 1; S_R_READY_i = 1; RID_i = 8'h61; RLAST_i = 1; RDATA_i = 32'h0BAD_F00D; RRESP_i = 0;
        S_W_VALID_i = 1; WREADY_i = 1; S_W_DATA_i = {32'h1234_5678, 4'hF, 1'b1};
        #1;
        check("both_r_valid", S_R_VALID_o, 1);
        check("both_wvalid", WVALID_o, 1);
        check("both_wlast", WLAST_o, 1);
        step();
        idle_inputs();
        BVALID_i = 1; S_B_READY_i = 1; BID_i = 8'h62;
        #1;
        check("both_b_valid", S_B_VALID_o, 1);
        check("both_r_idle", S_AR_READY_o, 1);
        step();
        idle_inputs();
        #1;
        check("both_w_idle", S_AW_READY_o, 1);
        check("both_err", PROTO_ERR_o, 0);

        random_phase(30, 0);

        // Single-beat write whose upstream last bit is wrong.
        do_write(8'h11, BASE, 4'd0, 3'd2, 2'd1, 32'h0, 0, 8'h11, 1, 0);
        apply_reset();
        // RLAST on the second beat of a four-beat read, then a BID mismatch.
        do_read(8'h12, BASE + 32'h40, 4'd3, 3'd2, 2'd1, 32'h40, 1, 8'h12, 1, 0);
        do_write(8'h13, BASE + 32'h8, 4'd0, 3'd2, 2'd1, 32'h8, -1, 8'h14, 1, 0);
        apply_reset();
        // RLAST missing at beat len: burst keeps going until RLAST.
        do_read(8'h15, BASE + 32'h4, 4'd2, 3'd2, 2'd1, 32'h4, 4, 8'h15, 1, 0);
        apply_reset();
        // RID mismatch alone.
        do_read(8'h16, BASE + 32'h4, 4'd1, 3'd2, 2'd1, 32'h4, 1, 8'h17, 1, 0);
        apply_reset();

        // Reset asserted mid W_DATA.
        S_AW_VALID_i = 1; S_AW_DATA_i = {8'h55, BASE + 32'h200, 4'd3, 3'd2, 2'd1};
        step();
        S_AW_VALID_i = 0; AWREADY_i = 1;
        step();
        AWREADY_i = 0; S_W_VALID_i = 1; WREADY_i = 1; S_W_DATA_i = {32'hDEAD_BEEF, 4'hF, 1'b0};
        #1 check("pre_rst_wvalid", WVALID_o, 1);
        #2 AXI_RST_i = 0;
        #1;
        check("async_rst_wvalid", WVALID_o, 0);
        check("async_rst_aw_ready", S_AW_READY_o, 1);
        check("async_rst_w_ready", S_W_READY_o, 0);
        check("async_rst_awaddr", AWADDR_o, 0);
        idle_inputs();
        step();
        AXI_RST_i = 1;
        exp_err = 1'b0;
        do_write(8'h56, BASE + 32'h300, 4'd2, 3'd2, 2'd1, 32'h300, -1, 8'h56, 1, 0);

        apply_reset();
        random_phase(20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
